// File: rtl/ba_lshift_pipe.sv
// ba_lshift_pipe -- pipelined logical left shifter with valid/ready flow control.
//
// One pipeline stage per bit of ctrl, most significant bit first: stage k
// shifts its word left by 2**(STAGES-1-k) when the matching ctrl bit is set,
// zero-filling from the LSB. The ctrl bits still to be applied travel with
// the word in per-stage registers. Each stage loads when it is empty or when
// its contents move on in the same cycle, so the pipeline sustains one word
// per cycle and stalls losslessly under back-pressure.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous, active-low reset; clears every stage
//   in_valid   upstream word and shift amount present
//   in_ready   block accepts the word this cycle
//   in         data word to shift (WIDTH bits)
//   ctrl       left-shift amount, unsigned (log2(WIDTH) bits)
//   out_valid  shifted word present on out
//   out_ready  downstream consumes out this cycle
//   out        in << ctrl, truncated to WIDTH bits
//   busy       any pipeline stage holds a valid word

module ba_lshift_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in,
    input  logic [$clog2(WIDTH)-1:0] ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     busy
);

    localparam int STAGES = $clog2(WIDTH);

    logic             vld    [STAGES];
    logic             rdy    [STAGES];
    logic [WIDTH-1:0] data_q [STAGES];
    // Carried ctrl bits; the final stage needs none.
    logic [STAGES-1:0] ctrl_q [STAGES-1];

    // Stage k may load unless it and every stage after it are full while
    // the output is stalled. Written as a flat scan rather than a chained
    // recurrence so the ready path has no self-referencing vector.
    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready;
            for (int unsigned j = k; j < STAGES; j++) begin
                if (!vld[j]) begin
                    rdy[k] = 1'b1;
                end
            end
            busy = busy | vld[k];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign out       = data_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SH = 1 << (STAGES - 1 - k);

        logic             sv;
        logic             sel;
        logic [WIDTH-1:0] sd;

        if (k == 0) begin : g_src
            assign sv  = in_valid;
            assign sel = ctrl[STAGES-1];
            assign sd  = in;
        end else begin : g_src
            assign sv  = vld[k-1];
            assign sel = ctrl_q[k-1][STAGES-1-k];
            assign sd  = data_q[k-1];
        end

        // Data only moves when the source holds a valid word, so an empty
        // stage keeps its old contents instead of toggling.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[k]    <= 1'b0;
                data_q[k] <= '0;
            end else if (rdy[k]) begin
                vld[k] <= sv;
                if (sv) begin
                    data_q[k] <= sel ? (sd << SH) : sd;
                end
            end
        end

        if (k < STAGES - 1) begin : g_carry
            // Keep only the ctrl bits later stages still have to apply.
            localparam logic [STAGES-1:0] KEEP = STAGES'((1 << (STAGES - 1 - k)) - 1);

            logic [STAGES-1:0] sc;

            if (k == 0) begin : g_csrc
                assign sc = ctrl;
            end else begin : g_csrc
                assign sc = ctrl_q[k-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctrl_q[k] <= '0;
                end else if (rdy[k] && sv) begin
                    ctrl_q[k] <= sc & KEEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_ba_lshift_pipe.sv
// Testbench for ba_lshift_pipe (WIDTH = 8): directed handshake/reset scenarios
// plus randomized traffic, with a scoreboard holding (in * 2**ctrl) mod 256 for
// every accepted word and comparing it against each word that leaves.

module tb_ba_lshift_pipe;

    localparam int WIDTH = 8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_d      = '0;
    logic [2:0] ctrl      = '0;
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic [7:0] out_d;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic       stall_prev = 1'b0;
    logic [7:0] held       = '0;

    ba_lshift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_d),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_d),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(input logic [7:0] v, input logic [2:0] s);
        int unsigned p;
        p = (int'(v) * (2 ** int'(s))) % 256;
        return 8'(p);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cyc();
        end
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    // Scoreboard: inputs are driven 1 ns after the rising edge, so at the
    // falling edge the handshake signals are settled for the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'(out_d), 32'(held));
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=0x%0h expected=none", out_d);
                end
                if (exp_q.size() != 0) begin
                    check("sb_out", 32'(out_d), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_d, ctrl));
            end
            stall_prev = out_valid && !out_ready;
            held       = out_d;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;

        // Reset state; a word offered during reset must not be taken.
        #1 rst_n = 1'b0;
        in_valid = 1'b1;
        in_d     = 8'h5A;
        ctrl     = 3'd1;
        cyc();
        cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out_d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        cyc();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Back-to-back words, latency and ordering.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_d = 8'h81; ctrl = 3'd1;
        cyc();
        check("lat_e0_valid", 32'(out_valid), 32'd0);
        in_d = 8'hFF; ctrl = 3'd7;
        cyc();
        check("lat_e1_valid", 32'(out_valid), 32'd0);
        in_d = 8'hA5; ctrl = 3'd4;
        cyc();
        check("seq0_valid", 32'(out_valid), 32'd1);
        check("seq0_out", 32'(out_d), 32'h02);
        in_d = 8'h3C; ctrl = 3'd0;
        cyc();
        check("seq1_valid", 32'(out_valid), 32'd1);
        check("seq1_out", 32'(out_d), 32'h80);
        in_valid = 1'b0;
        cyc();
        check("seq2_valid", 32'(out_valid), 32'd1);
        check("seq2_out", 32'(out_d), 32'h50);
        cyc();
        check("seq3_valid", 32'(out_valid), 32'd1);
        check("seq3_out", 32'(out_d), 32'h3C);
        drain();

        // Back-pressure: three words fill the pipe, the fourth waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_d      = 8'h01;
        for (int i = 1; i <= 3; i++) begin
            ctrl = 3'(i);
            #1 check("bp_fill_ready", 32'(in_ready), 32'd1);
            cyc();
        end
        ctrl = 3'd4;
        #1 check("bp_full_ready", 32'(in_ready), 32'd0);
        cyc();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_head", 32'(out_d), 32'h02);
        out_ready = 1'b1;
        #1 check("bp_rise_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("bp_out1", 32'(out_d), 32'h04);
        cyc();
        check("bp_out2", 32'(out_d), 32'h08);
        cyc();
        check("bp_out3", 32'(out_d), 32'h10);
        check("bp_out3_valid", 32'(out_valid), 32'd1);
        drain();

        // Random traffic with out_ready toggling every cycle.
        in_valid = 1'b1;
        in_d     = 8'($urandom);
        ctrl     = 3'($urandom_range(7));
        for (int i = 0; i < 300; i++) begin
            out_ready = (i % 2) == 0;
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (acc) begin
                in_d = 8'($urandom);
                ctrl = 3'($urandom_range(7));
            end
        end
        drain();
        check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with a full pipeline.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_d      = 8'hF0;
        ctrl      = 3'd2;
        cyc();
        cyc();
        cyc();
        check("ar_full_valid", 32'(out_valid), 32'd1);
        check("ar_full_out", 32'(out_d), 32'hC0);
        #3 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_out", 32'(out_d), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        in_valid = 1'b0;
        cyc();
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_d      = 8'h11;
        ctrl      = 3'd3;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("ar_new_e1_valid", 32'(out_valid), 32'd0);
        cyc();
        check("ar_new_valid", 32'(out_valid), 32'd1);
        check("ar_new_out", 32'(out_d), 32'h88);
        drain();

        // Exhaustive sweep at full throughput.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int v = 0; v < 256; v++) begin
            for (int s = 0; s < 8; s++) begin
                in_d = 8'(v);
                ctrl = 3'(s);
                #1 check("sweep_ready", 32'(in_ready), 32'd1);
                cyc();
            end
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        check("sweep_busy_tail", 32'(busy), 32'd1);
        cyc();
        check("sweep_busy_low", 32'(busy), 32'd0);
        check("sweep_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ba_lshift_pipe.md
BA_LSHIFT_PIPE -- requirements
Module: ba_lshift_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; power of two and at least 4.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  upstream word and shift amount are present.
REQ-005 Port: in_ready  output  1  block accepts the word this cycle.
REQ-006 Port: in  input  WIDTH  data word to shift.
REQ-007 Port: ctrl  input  log2(WIDTH)  left-shift amount, unsigned.
REQ-008 Port: out_valid  output  1  shifted word present on out.
REQ-009 Port: out_ready  input  1  downstream consumes out this cycle.
REQ-010 Port: out  output  WIDTH  in logically shifted left by ctrl, zero fill from LSB.
REQ-011 Port: busy  output  1  any pipeline stage holds a valid word.

Function
REQ-012 The block SHALL compute out = (in << ctrl) truncated to WIDTH bits, with vacated LSBs zero and shifted-out MSBs discarded.
- Logical shift only; no rotate, no sign fill.
REQ-013 There SHALL be one pipeline stage per ctrl bit, ordered MSB first.
- For WIDTH=8: stage 1 shifts by 4 if ctrl[2]; stage 2 by 2 if ctrl[1]; stage 3 by 1 if ctrl[0].
- Each stage uses a bank of 2:1 muxes feeding a data register and a valid register.
REQ-014 Each stage SHALL register the unused low ctrl bits alongside its data for the following stages.
REQ-015 A transfer in SHALL occur when in_valid and in_ready are both high on a rising clk edge.
REQ-016 A transfer out SHALL occur when out_valid and out_ready are both high on a rising clk edge.
REQ-017 Stage k SHALL load when it is empty or when its contents advance in the same cycle.
- Stage k is empty when its valid is 0.
- Stage k advances when stage k+1 loads; the last stage advances on a transfer out.
REQ-018 in_ready SHALL equal (stage-1 valid == 0) OR (stage 1 advancing this cycle).
- The ready chain is combinational from out_ready.
REQ-019 Latency SHALL be exactly 3 cycles (log2(WIDTH) in general) from a transfer in to out_valid high, when out_ready is held high.
REQ-020 Sustained throughput SHALL be one word per cycle when in_valid and out_ready are both held high.
REQ-021 While out_valid is high and out_ready is low, out SHALL hold stable and no stage SHALL lose or duplicate a word.
REQ-022 Words SHALL exit in acceptance order.
REQ-023 When all stages are full and out_ready is low, in_ready SHALL be low.
REQ-024 When all stages are full and out_ready goes high, in_ready SHALL go high in the same cycle.
- A word presented that cycle SHALL be accepted, so the pipeline stays full with no bubble.
REQ-025 A stage whose valid is 0 SHALL not be loaded from in or from a prior stage unless the source holds a valid word.
- Its data register is don't-care but SHALL hold its previous value, with no toggling.
REQ-026 busy SHALL be the OR of all stage valid bits.
REQ-027 ctrl = 0 SHALL pass in through unchanged with the same 3-cycle latency.
REQ-028 ctrl = WIDTH-1 SHALL yield out = {in[0], zeros}.

Reset
REQ-029 While rst_n is low, all stage valid bits, data registers and carried ctrl bits SHALL be 0.
- Consequently out_valid = 0, out = 0, busy = 0 and in_ready = 1.
REQ-030 Asserting rst_n low mid-operation SHALL discard all in-flight words immediately, without waiting for a clk edge.
REQ-031 No transfer in SHALL occur on the first rising edge at which rst_n is sampled low.
REQ-032 Normal operation SHALL resume on the first rising edge after rst_n is deasserted.

Verification
REQ-033 With out_ready=1, send in=0x81 ctrl=1, then 0xFF ctrl=7, then 0xA5 ctrl=4, then 0x3C ctrl=0, on consecutive cycles -> out is 0x02, 0x80, 0x50, 0x3C on cycles 3,4,5,6 after the first accept, out_valid high throughout.
REQ-034 Hold out_ready=0 and offer 4 words (0x01 with ctrl 1,2,3,4) -> first 3 accepted, in_ready low on the 4th; raise out_ready for 4 cycles -> outputs 0x02, 0x04, 0x08, 0x10 in order, 4th word accepted in the cycle out_ready rises.
REQ-035 Toggle out_ready 1/0 every cycle with continuous in_valid and random in/ctrl -> every output matches (in<<ctrl)&0xFF in order, no drops or duplicates, out stable while stalled.
REQ-036 Fill pipeline with 0xF0 ctrl=2 words, pulse rst_n low mid-cycle -> out_valid, busy, out go 0 asynchronously; after release, the first new word in=0x11 ctrl=3 yields 0x88 after 3 cycles.
REQ-037 Sweep all 256 in values x 8 ctrl values with out_ready=1 -> 2048 results match the reference model with zero mismatches; busy low 3 cycles after the last accept.
